// File: rtl/cnn_pkg.sv
// Shared widths and helpers for the CNN convolution-engine MAC datapath.
package cnn_pkg;

  localparam int OPERAND_W = 8;
  localparam int PRODUCT_W = 2 * OPERAND_W;
  localparam int ACC_W     = 19;
  localparam int MAX_TERMS = 8;
  localparam int CNT_W     = $clog2(MAX_TERMS);

  typedef logic [OPERAND_W-1:0] operand_t;
  typedef logic [PRODUCT_W-1:0] product_t;
  typedef logic [ACC_W-1:0]     acc_t;

  // Legal window length: 1..MAX_TERMS; 8 full-scale products still fit in ACC_W.
  function automatic bit terms_ok(input int n);
    return (n >= 1) && (n <= MAX_TERMS);
  endfunction

endpackage

// File: rtl/cnn_mac_datapath_if.sv
// Operand/result bundle between operand fetch, the MAC datapath and writeback.
interface cnn_mac_datapath_if;
  import cnn_pkg::*;

  logic     en;
  operand_t a;
  operand_t b;
  acc_t     muxer;

  modport master (output en, output a, output b, input muxer);
  modport slave  (input en, input a, input b, output muxer);

endinterface

// File: rtl/cnn_mac_datapath_mac_accumulator.sv
// S3 of the MAC pipeline: windowed accumulation of products and result register.
module mac_accumulator
  import cnn_pkg::*;
#(
  parameter int N_TERMS = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     en,
  input  product_t prod_q,
  output acc_t     res_q
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);

  logic [CNT_W-1:0] cnt;
  acc_t             acc;
  acc_t             acc_next;
  logic             last;

  // Term 0 restarts the sum, so the completing window and the next one overlap bubble-free.
  always_comb begin
    last     = (cnt == LAST);
    acc_next = (cnt == '0) ? ACC_W'(prod_q) : acc + ACC_W'(prod_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt   <= '0;
      acc   <= '0;
      res_q <= '0;
    end else if (en) begin
      acc <= acc_next;
      if (last) begin
        res_q <= acc_next;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cnn_mac_datapath.sv
// Three-stage unsigned 8x8 multiply-accumulate over fixed windows of N_TERMS products.
module cnn_mac_datapath
  import cnn_pkg::*;
#(
  parameter int N_TERMS = 4
) (
  input logic               clk,
  input logic               rst,
  cnn_mac_datapath_if.slave bus
);

  if (!terms_ok(N_TERMS)) begin : g_bad_n_terms
    $error("cnn_mac_datapath: N_TERMS must be in 1..MAX_TERMS");
  end

  operand_t a_q;
  operand_t b_q;
  product_t prod_q;
  acc_t     res_q;

  // Reset-zero contents of S1/S2 flow into S3 as ordinary terms during pipeline fill.
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_q    <= '0;
      b_q    <= '0;
      prod_q <= '0;
    end else if (bus.en) begin
      a_q    <= bus.a;
      b_q    <= bus.b;
      prod_q <= PRODUCT_W'(a_q) * PRODUCT_W'(b_q);
    end
  end

  mac_accumulator #(
    .N_TERMS (N_TERMS)
  ) u_acc (
    .clk    (clk),
    .rst    (rst),
    .en     (bus.en),
    .prod_q (prod_q),
    .res_q  (res_q)
  );

  assign bus.muxer = res_q;

endmodule

// File: tb/tb_cnn_mac_datapath.sv
// Self-checking bench: three datapath instances (N_TERMS = 4, 8, 1) against a window-sum model.
module tb_cnn_mac_datapath;

  logic        clk;
  logic        rst_v [3];
  logic        en_v  [3];
  logic [7:0]  a_v   [3];
  logic [7:0]  b_v   [3];
  logic [18:0] mux_v [3];
  logic [18:0] exp_v [3];

  int          nt [3] = '{4, 8, 1};
  int          nslot [3];
  int unsigned prod_h [3][4096];

  int checks = 0;
  int errors = 0;

  byte unsigned pa [16] = '{1, 2, 3, 4, 1, 2, 3, 4, 1, 2, 3, 4, 1, 2, 3, 4};
  byte unsigned pb [16] = '{1, 2, 4, 5, 2, 3, 5, 6, 4, 5, 7, 8, 5, 6, 8, 9};

  cnn_mac_datapath_if bus4 ();
  cnn_mac_datapath_if bus8 ();
  cnn_mac_datapath_if bus1 ();

  assign bus4.en = en_v[0];
  assign bus4.a  = a_v[0];
  assign bus4.b  = b_v[0];
  assign bus8.en = en_v[1];
  assign bus8.a  = a_v[1];
  assign bus8.b  = b_v[1];
  assign bus1.en = en_v[2];
  assign bus1.a  = a_v[2];
  assign bus1.b  = b_v[2];
  assign mux_v[0] = bus4.muxer;
  assign mux_v[1] = bus8.muxer;
  assign mux_v[2] = bus1.muxer;

  cnn_mac_datapath #(.N_TERMS(4)) dut4 (.clk(clk), .rst(rst_v[0]), .bus(bus4));
  cnn_mac_datapath #(.N_TERMS(8)) dut8 (.clk(clk), .rst(rst_v[1]), .bus(bus8));
  cnn_mac_datapath #(.N_TERMS(1)) dut1 (.clk(clk), .rst(rst_v[2]), .bus(bus1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [18:0] obs, input logic [18:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: muxer=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Term k reaching S3 since reset release: two fill zeros, then the sampled pairs in order.
  function automatic int unsigned arrival(input int d, input int k);
    return (k < 2) ? 0 : prod_h[d][k-2];
  endfunction

  task automatic tick();
    @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      if (!rst_v[d]) begin
        nslot[d] = 0;
        exp_v[d] = '0;
      end else if (en_v[d]) begin
        prod_h[d][nslot[d]] = int'(a_v[d]) * int'(b_v[d]);
        if ((nslot[d] + 1) % nt[d] == 0) begin
          int unsigned s;
          s = 0;
          for (int k = nslot[d] - nt[d] + 1; k <= nslot[d]; k++) s += arrival(d, k);
          exp_v[d] = 19'(s);
        end
        nslot[d]++;
      end
    end
    #1;
    for (int d = 0; d < 3; d++) check($sformatf("model_n%0d", nt[d]), mux_v[d], exp_v[d]);
  endtask

  task automatic reset_dut(input int d);
    rst_v[d] = 1'b0;
    en_v[d]  = 1'b1;
    a_v[d]   = 8'($urandom);
    b_v[d]   = 8'($urandom);
    tick();
    rst_v[d] = 1'b1;
    en_v[d]  = 1'b0;
  endtask

  // Stimulus index i: two zero slots, the 16 test pairs, then zero flush.
  task automatic set_stim(input int i);
    if (i < 2 || i >= 18) begin
      a_v[0] = 8'd0;
      b_v[0] = 8'd0;
    end else begin
      a_v[0] = pa[i-2];
      b_v[0] = pb[i-2];
    end
  endtask

  task automatic run_windows(input int stall_at, input string tag);
    logic [18:0] seen [$];
    logic [18:0] last_v;
    logic [18:0] want [4];
    want = '{19'd37, 19'd47, 19'd67, 19'd77};
    reset_dut(0);
    last_v = '0;
    for (int i = 0; i < 21; i++) begin
      if (i == stall_at) begin
        en_v[0] = 1'b0;
        for (int s = 0; s < 5; s++) begin
          a_v[0] = 8'($urandom);
          b_v[0] = 8'($urandom);
          tick();
          if (mux_v[0] !== last_v) begin seen.push_back(mux_v[0]); last_v = mux_v[0]; end
        end
      end
      en_v[0] = 1'b1;
      set_stim(i);
      tick();
      if (mux_v[0] !== last_v) begin seen.push_back(mux_v[0]); last_v = mux_v[0]; end
    end
    en_v[0] = 1'b0;
    check({tag, "_count"}, 19'(seen.size()), 19'd4);
    for (int k = 0; k < 4; k++)
      check($sformatf("%s_w%0d", tag, k), (k < seen.size()) ? seen[k] : 19'bx, want[k]);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst_v[d] = 1'b0;
      en_v[d]  = 1'b1;
      a_v[d]   = 8'd255;
      b_v[d]   = 8'd255;
      nslot[d] = 0;
      exp_v[d] = '0;
    end

    // Reset held 3 cycles with en=1 and full-scale operands.
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_hold", mux_v[0], 19'd0);
    end
    for (int d = 0; d < 3; d++) rst_v[d] = 1'b1;
    tick();
    check("rst_release", mux_v[0], 19'd0);
    for (int d = 0; d < 3; d++) en_v[d] = 1'b0;

    // Window sums back-to-back, then with a 5-cycle stall mid-window.
    run_windows(-1, "win");
    run_windows(9, "stall");

    // Reset two terms into a window, then a fresh window.
    reset_dut(0);
    en_v[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin set_stim(i); tick(); end
    rst_v[0] = 1'b0;
    tick();
    check("midrst_zero", mux_v[0], 19'd0);
    rst_v[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin set_stim(i); tick(); end
    set_stim(18); tick(); tick();
    check("midrst_win", mux_v[0], 19'd37);
    en_v[0] = 1'b0;

    // Full-scale window with N_TERMS = 8.
    reset_dut(1);
    en_v[1] = 1'b1;
    a_v[1]  = 8'd255;
    b_v[1]  = 8'd255;
    repeat (20) tick();
    check("max_n8", mux_v[1], 19'd520200);
    en_v[1] = 1'b0;

    // N_TERMS = 1 follows each product with 2-cycle latency.
    reset_dut(2);
    en_v[2] = 1'b1;
    b_v[2]  = 8'd2;
    a_v[2] = 8'd3; tick();
    a_v[2] = 8'd5; tick();
    a_v[2] = 8'd7; tick();
    check("n1_first", mux_v[2], 19'd6);
    a_v[2] = 8'd0; tick();
    check("n1_second", mux_v[2], 19'd10);
    tick();
    check("n1_third", mux_v[2], 19'd14);

    // Random operands, enables and occasional resets on all three instances.
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 3; d++) begin
        rst_v[d] = ($urandom_range(0, 49) != 0);
        en_v[d]  = ($urandom_range(0, 3) != 0);
        a_v[d]   = 8'($urandom);
        b_v[d]   = 8'($urandom);
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
